// File: rtl/traffic_generator_gmii_scheduler.sv
// Frame request sequencer for the GMII traffic generator: latches the
// run configuration, spaces frames by IFG/IBG and tracks run progress.
module traffic_generator_gmii_scheduler #(
   parameter int GAP_WIDTH = 32,
   parameter int CNT_WIDTH = 64,
   parameter int LEN_WIDTH = 16,
   parameter int MIN_GAP   = 12
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 enable,
   input  logic [GAP_WIDTH-1:0] interframe_gap,
   input  logic [GAP_WIDTH-1:0] interburst_gap,
   input  logic [31:0]          frames_per_burst,
   input  logic [CNT_WIDTH-1:0] total_frames,
   input  logic [LEN_WIDTH-1:0] frame_size,
   output logic                 frame_req,
   output logic [LEN_WIDTH-1:0] frame_len,
   input  logic                 frame_ack,
   input  logic                 frame_done,
   output logic                 busy,
   output logic                 run_done,
   output logic                 config_err,
   output logic [CNT_WIDTH-1:0] frames_sent
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_TX,
      S_IFG,
      S_IBG,
      S_DONE
   } state_t;

   localparam logic [GAP_WIDTH-1:0] GAP_MIN = GAP_WIDTH'(MIN_GAP);
   localparam logic [GAP_WIDTH-1:0] GAP_ONE = GAP_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   state_t               state;
   logic                 rst_meta;
   logic                 rst_n;
   logic                 enable_q;
   logic [GAP_WIDTH-1:0] ifg_s;
   logic [GAP_WIDTH-1:0] ibg_s;
   logic [GAP_WIDTH-1:0] gap_cnt;
   logic [31:0]          fpb_s;
   logic [31:0]          burst_cnt;
   logic [CNT_WIDTH-1:0] total_s;
   logic [LEN_WIDTH-1:0] size_s;

   logic                 start;
   logic                 last_frame;
   logic                 last_in_burst;
   logic [GAP_WIDTH-1:0] ifg_eff;
   logic [GAP_WIDTH-1:0] ibg_eff;
   logic [CNT_WIDTH-1:0] sent_nx;
   logic [31:0]          burst_nx;

   // Reset asserts asynchronously but releases on a clock edge.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rst_meta <= 1'b0;
         rst_n    <= 1'b0;
      end else begin
         rst_meta <= 1'b1;
         rst_n    <= rst_meta;
      end
   end

   assign start         = enable & ~enable_q;
   assign sent_nx       = frames_sent + CNT_ONE;
   assign burst_nx      = burst_cnt + 32'd1;
   assign last_frame    = (total_s != '0) && (sent_nx == total_s);
   assign last_in_burst = (fpb_s != '0) && (burst_nx == fpb_s);
   assign ifg_eff       = (ifg_s < GAP_MIN) ? GAP_MIN : ifg_s;
   assign ibg_eff       = (ibg_s < GAP_MIN) ? GAP_MIN : ibg_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         enable_q    <= 1'b0;
         ifg_s       <= '0;
         ibg_s       <= '0;
         fpb_s       <= '0;
         total_s     <= '0;
         size_s      <= '0;
         gap_cnt     <= '0;
         burst_cnt   <= '0;
         frame_req   <= 1'b0;
         frame_len   <= '0;
         busy        <= 1'b0;
         run_done    <= 1'b0;
         config_err  <= 1'b0;
         frames_sent <= '0;
      end else begin
         enable_q <= enable;
         unique case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  ifg_s   <= interframe_gap;
                  ibg_s   <= interburst_gap;
                  fpb_s   <= frames_per_burst;
                  total_s <= total_frames;
                  size_s  <= frame_size;
                  if (frame_size == '0) begin
                     config_err <= 1'b1;
                     run_done   <= 1'b0;
                     state      <= S_IDLE;
                  end else begin
                     config_err  <= 1'b0;
                     run_done    <= 1'b0;
                     busy        <= 1'b1;
                     frame_req   <= 1'b1;
                     frame_len   <= frame_size;
                     frames_sent <= '0;
                     burst_cnt   <= '0;
                     state       <= S_REQ;
                  end
               end
            end
            S_REQ: begin
               if (!enable) begin
                  frame_req <= 1'b0;
                  busy      <= 1'b0;
                  state     <= S_IDLE;
               end else if (frame_ack) begin
                  frame_req <= 1'b0;
                  state     <= S_TX;
               end
            end
            S_TX: begin
               if (frame_done) begin
                  frames_sent <= sent_nx;
                  burst_cnt   <= burst_nx;
                  // A stop lets the frame finish but never reports DONE.
                  if (!enable) begin
                     busy  <= 1'b0;
                     state <= S_IDLE;
                  end else if (last_frame) begin
                     busy     <= 1'b0;
                     run_done <= 1'b1;
                     state    <= S_DONE;
                  end else if (last_in_burst) begin
                     burst_cnt <= '0;
                     gap_cnt   <= ibg_eff;
                     state     <= S_IBG;
                  end else begin
                     gap_cnt <= ifg_eff;
                     state   <= S_IFG;
                  end
               end
            end
            S_IFG, S_IBG: begin
               if (!enable) begin
                  gap_cnt <= '0;
                  busy    <= 1'b0;
                  state   <= S_IDLE;
               end else if (gap_cnt == GAP_ONE) begin
                  gap_cnt   <= '0;
                  frame_req <= 1'b1;
                  frame_len <= size_s;
                  state     <= S_REQ;
               end else begin
                  gap_cnt <= gap_cnt - GAP_ONE;
               end
            end
            default: begin
               frame_req <= 1'b0;
               busy      <= 1'b0;
               state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_traffic_generator_gmii_scheduler.sv
// Scoreboard bench for the frame scheduler: a transmitter model answers
// requests while a monitor checks lengths and gaps against expectations.
module tb_traffic_generator_gmii_scheduler;

   logic        clk;
   logic        resetn;
   logic        enable;
   logic [31:0] interframe_gap;
   logic [31:0] interburst_gap;
   logic [31:0] frames_per_burst;
   logic [63:0] total_frames;
   logic [15:0] frame_size;
   logic        frame_req;
   logic [15:0] frame_len;
   logic        frame_ack;
   logic        frame_done;
   logic        busy;
   logic        run_done;
   logic        config_err;
   logic [63:0] frames_sent;

   traffic_generator_gmii_scheduler dut (
      .clk              (clk),
      .resetn           (resetn),
      .enable           (enable),
      .interframe_gap   (interframe_gap),
      .interburst_gap   (interburst_gap),
      .frames_per_burst (frames_per_burst),
      .total_frames     (total_frames),
      .frame_size       (frame_size),
      .frame_req        (frame_req),
      .frame_len        (frame_len),
      .frame_ack        (frame_ack),
      .frame_done       (frame_done),
      .busy             (busy),
      .run_done         (run_done),
      .config_err       (config_err),
      .frames_sent      (frames_sent)
   );

   typedef struct {
      int len;
      int gap;
   } exp_t;

   exp_t exp_q[$];
   int   total_cnt = 0;
   int   bad_cnt   = 0;

   int ack_lo = 0, ack_hi = 3;
   int done_lo = 5, done_hi = 20;
   int ack_count = 0, done_count = 0;
   int rphase = 0, rcnt = 0;

   int cyc = 0, last_done = 0, req_cycles = 0, cur_len = 0;
   bit req_prev = 0;
   exp_t me;

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(string name, longint act, longint exp);
      total_cnt++;
      if (act !== exp) begin
         bad_cnt++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   // Reference model: frame i waits the IBG if it opens a new burst,
   // otherwise the IFG, never less than 12 cycles.
   task automatic push_run(int size, int nfr, int fpb, int ifg, int ibg);
      exp_t e;
      for (int i = 0; i < nfr; i++) begin
         int g;
         e.len = size;
         if (i == 0) e.gap = -1;
         else begin
            g = (fpb != 0 && i % fpb == 0) ? ibg : ifg;
            e.gap = (g < 12) ? 12 : g;
         end
         exp_q.push_back(e);
      end
   endtask

   // Transmitter model
   initial begin
      frame_ack  = 0;
      frame_done = 0;
      forever begin
         @(negedge clk);
         frame_ack  = 0;
         frame_done = 0;
         if (!resetn) rphase = 0;
         else if (rphase == 0 && frame_req) begin
            rcnt   = $urandom_range(ack_hi, ack_lo);
            rphase = 1;
         end
         if (rphase == 1) begin
            if (!frame_req) rphase = 0;
            else if (rcnt == 0) begin
               frame_ack = 1;
               ack_count++;
               rcnt   = $urandom_range(done_hi, done_lo);
               rphase = 2;
            end else rcnt--;
         end else if (rphase == 2) begin
            if (rcnt <= 1) begin
               frame_done = 1;
               done_count++;
               rphase = 0;
            end else rcnt--;
         end
      end
   end

   // Monitor
   initial begin
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (frame_req && !req_prev) begin
            if (exp_q.size() == 0) begin
               total_cnt++;
               bad_cnt++;
               $display("FAIL unexpected_req: got frame_req=1 required 0 at cycle %0d", cyc);
            end else begin
               me = exp_q.pop_front();
               cur_len = me.len;
               chk("frame_len", frame_len, me.len);
               if (me.gap >= 0) chk("gap", cyc - last_done, me.gap);
            end
            req_cycles = 1;
         end else if (frame_req) begin
            req_cycles++;
            chk("len_stable", frame_len, cur_len);
         end
         req_prev = frame_req;
         if (frame_done) last_done = cyc;
      end
   end

   task automatic wait_run_done(int lim);
      int n = 0;
      while (!run_done && n < lim) begin
         @(negedge clk);
         n++;
      end
      total_cnt++;
      if (!run_done) begin
         bad_cnt++;
         $display("FAIL run_done_wait: got 0 required 1 within %0d cycles", lim);
      end
   endtask

   task automatic wait_busy_low(int lim);
      int n = 0;
      while (busy && n < lim) begin
         @(negedge clk);
         n++;
      end
      total_cnt++;
      if (busy) begin
         bad_cnt++;
         $display("FAIL busy_low_wait: got 1 required 0 within %0d cycles", lim);
      end
   endtask

   task automatic wait_acks(int target, int lim);
      int n = 0;
      while (ack_count < target && n < lim) begin
         @(negedge clk);
         n++;
      end
      chk("ack_wait", ack_count, target);
   endtask

   task automatic wait_dones(int target, int lim);
      int n = 0;
      while (done_count < target && n < lim) begin
         @(negedge clk);
         n++;
      end
      chk("done_wait", done_count, target);
   endtask

   task automatic start_run(int size, int tot, int fpb, int ifg, int ibg);
      enable = 0;
      @(negedge clk);
      frame_size       = 16'(size);
      total_frames     = 64'(tot);
      frames_per_burst = 32'(fpb);
      interframe_gap   = 32'(ifg);
      interburst_gap   = 32'(ibg);
      enable = 1;
      @(negedge clk);
      // Live inputs change after the start; the run must ignore them.
      frame_size       = 16'($urandom_range(1, 2000));
      total_frames     = 64'($urandom_range(1, 9));
      frames_per_burst = $urandom_range(0, 4);
      interframe_gap   = $urandom_range(0, 60);
      interburst_gap   = $urandom_range(0, 60);
   endtask

   task automatic run_full(int size, int tot, int fpb, int ifg, int ibg);
      push_run(size, tot, fpb, ifg, ibg);
      start_run(size, tot, fpb, ifg, ibg);
      chk("busy_running", busy, 1);
      wait_run_done(20000);
      chk("frames_sent_end", frames_sent, tot);
      chk("busy_done", busy, 0);
      chk("exp_left", exp_q.size(), 0);
      repeat (15) @(negedge clk);
      chk("run_done_hold", run_done, 1);
      chk("config_err_run", config_err, 0);
      enable = 0;
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: got no finish required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      resetn = 0;
      enable = 0;
      interframe_gap = 0;
      interburst_gap = 0;
      frames_per_burst = 0;
      total_frames = 0;
      frame_size = 0;
      repeat (3) @(negedge clk);
      resetn = 1;
      repeat (4) @(negedge clk);
      chk("rst_frame_req", frame_req, 0);
      chk("rst_busy", busy, 0);
      chk("rst_run_done", run_done, 0);
      chk("rst_config_err", config_err, 0);
      chk("rst_frames_sent", frames_sent, 0);
      chk("rst_frame_len", frame_len, 0);

      ack_lo = 0; ack_hi = 0; done_lo = 70; done_hi = 70;
      run_full(64, 3, 0, 20, 0);

      ack_lo = 0; ack_hi = 3; done_lo = 5; done_hi = 20;
      run_full(256, 6, 2, 12, 100);
      run_full(100, 4, 1, 3, 0);

      ack_lo = 10; ack_hi = 10;
      run_full(512, 2, 0, 15, 0);
      chk("req_hold_cycles", req_cycles, 11);

      ack_lo = 0; ack_hi = 4; done_lo = 1; done_hi = 30;
      for (int r = 0; r < 6; r++)
         run_full($urandom_range(1, 1518), $urandom_range(1, 5),
                  $urandom_range(0, 3), $urandom_range(0, 25),
                  $urandom_range(0, 40));

      enable = 0;
      @(negedge clk);
      frame_size = 0;
      total_frames = 1;
      enable = 1;
      @(negedge clk);
      chk("cfg_err_set", config_err, 1);
      chk("cfg_err_busy", busy, 0);
      repeat (5) @(negedge clk);
      chk("cfg_err_idle", busy, 0);
      run_full(128, 1, 0, 12, 12);

      done_lo = 20; done_hi = 30;
      base = ack_count;
      push_run(200, 5, 0, 12, 0);
      start_run(200, 0, 0, 12, 0);
      wait_acks(base + 5, 3000);
      repeat (2) @(negedge clk);
      enable = 0;
      wait_busy_low(200);
      chk("stop_tx_sent", frames_sent, 5);
      chk("stop_tx_no_done", run_done, 0);
      repeat (100) @(negedge clk);
      chk("stop_tx_req", frame_req, 0);
      chk("stop_tx_left", exp_q.size(), 0);

      base = done_count;
      push_run(300, 1, 0, 30, 0);
      start_run(300, 0, 0, 30, 0);
      wait_dones(base + 1, 500);
      repeat (3) @(negedge clk);
      chk("ifg_busy_before", busy, 1);
      enable = 0;
      @(posedge clk);
      #1;
      chk("stop_ifg_busy", busy, 0);
      chk("stop_ifg_req", frame_req, 0);
      repeat (60) @(negedge clk);
      chk("stop_ifg_sent", frames_sent, 1);
      chk("stop_ifg_left", exp_q.size(), 0);

      base = done_count;
      push_run(100, 1, 1, 12, 200);
      start_run(100, 0, 1, 12, 200);
      wait_dones(base + 1, 500);
      repeat (5) @(negedge clk);
      chk("ibg_busy_before", busy, 1);
      chk("ibg_sent_before", frames_sent, 1);
      #2;
      resetn = 0;
      enable = 0;
      #1;
      chk("async_rst_req", frame_req, 0);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_sent", frames_sent, 0);
      @(negedge clk);
      resetn = 1;
      exp_q.delete();
      repeat (50) @(negedge clk);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_sent", frames_sent, 0);

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
